// File: rtl/phys_mem_pkg.sv
// Shared types and helpers for the physical RAM stage: word width, port-A request
// record used for the shadow compare, and the byte-to-word index mapping.
package phys_mem_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } phys_req_t;

  function automatic logic [29:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/phys_ram_if.sv
// Bus bundle between the memory controller / DMA side (master) and the physical
// RAM arbiter (slave): level-signalled port A, req/gnt port B and the OOR trap.
interface phys_ram_if;
  import phys_mem_pkg::*;

  logic [31:0]       a_addr;
  logic [WORD_W-1:0] a_wdata;
  logic              a_read_req;
  logic              a_write_req;
  logic [WORD_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [31:0]       b_addr;
  logic [WORD_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [WORD_W-1:0] b_rdata;

  logic              oor_err;
  logic [31:0]       oor_addr;

  modport master (
    output a_addr, a_wdata, a_read_req, a_write_req,
    input  a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  oor_err, oor_addr
  );

  modport slave (
    input  a_addr, a_wdata, a_read_req, a_write_req,
    output a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output oor_err, oor_addr
  );

endinterface

// File: rtl/phys_ram_arbiter_core.sv
// Single-port, read-first, synchronous 32-bit RAM. Contents are undefined until written.
module phys_ram_core
  import phys_mem_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Read-first: rdata always returns the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem_q[idx];
      if (we) mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/phys_ram_arbiter.sv
// Physical RAM arbiter: port A (level requests, absolute priority, fixed timing) and
// port B (req/gnt, fills idle cycles). Optional out-of-range trap: PHYS_RAM_OOR_TRAP_EN.
module phys_ram_arbiter
  import phys_mem_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  phys_ram_if.slave  bus
);

  phys_req_t         a_cur;
  phys_req_t         a_shadow_q;
  logic              a_new;
  logic              a_acc;
  logic              b_gnt;
  logic              a_oor;
  logic              b_oor;
  logic [29:0]       a_widx;
  logic [29:0]       b_widx;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_idx;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  logic              a_rd_d, a_rd_q;
  logic              a_zero_q;
  logic              b_rv_d, b_rv_q;
  logic              b_zero_q;
  logic [WORD_W-1:0] a_hold_q;
  logic [WORD_W-1:0] b_hold_q;
  logic [WORD_W-1:0] a_data;
  logic [WORD_W-1:0] b_data;

  // A request is issued only when it differs from what was presented last cycle.
  assign a_cur  = '{addr: bus.a_addr, wdata: bus.a_wdata,
                    rd: bus.a_read_req, wr: bus.a_write_req};
  assign a_new  = (a_cur.rd | a_cur.wr) & (a_cur != a_shadow_q);
  assign a_acc  = a_new & ~reset;
  assign b_gnt  = bus.b_req & ~a_new & ~reset;
  assign bus.b_gnt = b_gnt;

  assign a_widx = word_idx(bus.a_addr);
  assign b_widx = word_idx(bus.b_addr);

`ifdef PHYS_RAM_OOR_TRAP_EN
  assign a_oor = |bus.a_addr[31:ADDR_W+2];
  assign b_oor = |bus.b_addr[31:ADDR_W+2];
`else
  assign a_oor = 1'b0;
  assign b_oor = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{a_widx[29:ADDR_W], b_widx[29:ADDR_W]};

  assign ram_en    = a_acc | b_gnt;
  assign ram_we    = a_acc ? (a_cur.wr & ~a_oor) : (bus.b_we & ~b_oor);
  assign ram_idx   = a_acc ? a_widx[ADDR_W-1:0] : b_widx[ADDR_W-1:0];
  assign ram_wdata = a_acc ? bus.a_wdata : bus.b_wdata;

  phys_ram_core #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign a_rd_d = a_acc & a_cur.rd;
  assign b_rv_d = b_gnt & ~bus.b_we;

  // p1 stage: RAM output is live for one cycle after a read, then parked in a hold register
  // so later traffic on the shared RAM output never disturbs either port's data.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_shadow_q <= '0;
      a_rd_q     <= 1'b0;
      a_zero_q   <= 1'b0;
      b_rv_q     <= 1'b0;
      b_zero_q   <= 1'b0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      a_shadow_q <= a_cur;
      a_rd_q     <= a_rd_d;
      a_zero_q   <= a_oor;
      b_rv_q     <= b_rv_d;
      b_zero_q   <= b_oor;
      if (a_rd_q) a_hold_q <= a_data;
      if (b_rv_q) b_hold_q <= b_data;
    end
  end

  assign a_data = a_zero_q ? '0 : ram_rdata;
  assign b_data = b_zero_q ? '0 : ram_rdata;

  assign bus.a_rdata  = a_rd_q ? a_data : a_hold_q;
  assign bus.b_rdata  = b_rv_q ? b_data : b_hold_q;
  assign bus.b_rvalid = b_rv_q;

`ifdef PHYS_RAM_OOR_TRAP_EN
  logic        oor_err_q;
  logic [31:0] oor_addr_q;

  // Sticky: only the first offending access is recorded; A is checked before B.
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_err_q  <= 1'b0;
      oor_addr_q <= '0;
    end else if (!oor_err_q) begin
      if (a_acc & a_oor) begin
        oor_err_q  <= 1'b1;
        oor_addr_q <= bus.a_addr;
      end else if (b_gnt & b_oor) begin
        oor_err_q  <= 1'b1;
        oor_addr_q <= bus.b_addr;
      end
    end
  end

  assign bus.oor_err  = oor_err_q;
  assign bus.oor_addr = oor_addr_q;
`else
  assign bus.oor_err  = 1'b0;
  assign bus.oor_addr = '0;
`endif

endmodule
